// File: rtl/csr_ctrl_if.sv
// Bundle of the request, response and CSR-file access signals around csr_ctrl.
// slave is the csr_ctrl view; master is the decode/write-back/CSR-file side.
interface csr_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_funct3;
  logic                  in_is_ecall;
  logic                  in_is_mret;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [4:0]            in_rs1_idx;
  logic [DATA_WIDTH-1:0] in_pc;

  logic [ADDR_WIDTH-1:0] csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_wen;
  logic                  csr_is_ecall;
  logic                  csr_is_mret;
  logic [DATA_WIDTH-1:0] csr_pc;
  logic [DATA_WIDTH-1:0] csr_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic                  out_redirect;
  logic [DATA_WIDTH-1:0] out_npc;
  logic                  out_illegal;

  modport master (
    output in_valid, in_funct3, in_is_ecall, in_is_mret, in_addr, in_rs1,
           in_rs1_idx, in_pc, csr_rdata, out_ready,
    input  in_ready, csr_addr, csr_wdata, csr_wen, csr_is_ecall, csr_is_mret,
           csr_pc, out_valid, out_rdata, out_redirect, out_npc, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_is_ecall, in_is_mret, in_addr, in_rs1,
           in_rs1_idx, in_pc, csr_rdata, out_ready,
    output in_ready, csr_addr, csr_wdata, csr_wen, csr_is_ecall, csr_is_mret,
           csr_pc, out_valid, out_rdata, out_redirect, out_npc, out_illegal
  );
endinterface

// File: rtl/csr_ctrl.sv
// CSR access sequencer: IDLE -> READ -> WRITE -> RESP read-modify-write of the CSR file.
// Define CSR_CTRL_ZICSR_IMM_EN to support the immediate forms (CSRRWI/CSRRSI/CSRRCI).
module csr_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic         clk,
  input  logic         rst,
  csr_ctrl_if.slave    bus
);

`ifdef CSR_CTRL_ZICSR_IMM_EN
  localparam logic IMM_EN = 1'b1;
`else
  localparam logic IMM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic [2:0]            f3_q;
  logic                  ecall_q, mret_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [4:0]            idx_q;
  logic [DATA_WIDTH-1:0] old_q, old_d;

  logic [ADDR_WIDTH-1:0] csr_addr_q, csr_addr_d;
  logic [DATA_WIDTH-1:0] csr_wdata_q, csr_wdata_d;
  logic                  csr_wen_q, csr_wen_d;
  logic                  csr_ecall_q, csr_ecall_d;
  logic                  csr_mret_q, csr_mret_d;
  logic [DATA_WIDTH-1:0] csr_pc_q, csr_pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
  logic                  out_redirect_q, out_redirect_d;
  logic [DATA_WIDTH-1:0] out_npc_q, out_npc_d;
  logic                  out_illegal_q, out_illegal_d;

  logic                  accept;
  logic                  in_legal;
  logic [DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0] new_val;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign in_legal = (bus.in_funct3[1:0] != 2'b00) && (!bus.in_funct3[2] || IMM_EN);

  // Modify step uses the live read port during READ so the new value is registered
  // straight into csr_wdata for the WRITE cycle.
  always_comb begin
    src = (f3_q[2] && IMM_EN) ? DATA_WIDTH'(idx_q) : rs1_q;
    unique case (f3_q[1:0])
      2'b10:   new_val = bus.csr_rdata | src;
      2'b11:   new_val = bus.csr_rdata & ~src;
      default: new_val = src;
    endcase
  end

  // All outputs are registered from the next-state decode so pulses are glitch-free.
  always_comb begin
    state_d        = state_q;
    old_d          = old_q;
    csr_addr_d     = '0;
    csr_wdata_d    = '0;
    csr_wen_d      = 1'b0;
    csr_ecall_d    = 1'b0;
    csr_mret_d     = 1'b0;
    csr_pc_d       = '0;
    out_valid_d    = out_valid_q;
    out_rdata_d    = out_rdata_q;
    out_redirect_d = out_redirect_q;
    out_npc_d      = out_npc_q;
    out_illegal_d  = out_illegal_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_is_ecall) begin
            state_d     = READ;
            csr_addr_d  = bus.in_addr;
            csr_ecall_d = 1'b1;
            csr_pc_d    = bus.in_pc;
          end else if (bus.in_is_mret) begin
            state_d    = READ;
            csr_addr_d = bus.in_addr;
            csr_mret_d = 1'b1;
          end else if (!in_legal) begin
            state_d        = RESP;
            out_valid_d    = 1'b1;
            out_rdata_d    = '0;
            out_redirect_d = 1'b0;
            out_npc_d      = '0;
            out_illegal_d  = 1'b1;
          end else begin
            state_d    = READ;
            csr_addr_d = bus.in_addr;
          end
        end
      end
      READ: begin
        if (ecall_q || mret_q) begin
          state_d        = RESP;
          out_valid_d    = 1'b1;
          out_rdata_d    = '0;
          out_redirect_d = 1'b1;
          out_npc_d      = bus.csr_rdata;
          out_illegal_d  = 1'b0;
        end else begin
          state_d     = WRITE;
          old_d       = bus.csr_rdata;
          csr_addr_d  = addr_q;
          csr_wdata_d = new_val;
          csr_wen_d   = !(f3_q[1] && (idx_q == '0));
        end
      end
      WRITE: begin
        state_d        = RESP;
        out_valid_d    = 1'b1;
        out_rdata_d    = old_q;
        out_redirect_d = 1'b0;
        out_npc_d      = '0;
        out_illegal_d  = 1'b0;
      end
      RESP: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      f3_q           <= '0;
      ecall_q        <= 1'b0;
      mret_q         <= 1'b0;
      addr_q         <= '0;
      rs1_q          <= '0;
      idx_q          <= '0;
      old_q          <= '0;
      csr_addr_q     <= '0;
      csr_wdata_q    <= '0;
      csr_wen_q      <= 1'b0;
      csr_ecall_q    <= 1'b0;
      csr_mret_q     <= 1'b0;
      csr_pc_q       <= '0;
      out_valid_q    <= 1'b0;
      out_rdata_q    <= '0;
      out_redirect_q <= 1'b0;
      out_npc_q      <= '0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      old_q          <= old_d;
      csr_addr_q     <= csr_addr_d;
      csr_wdata_q    <= csr_wdata_d;
      csr_wen_q      <= csr_wen_d;
      csr_ecall_q    <= csr_ecall_d;
      csr_mret_q     <= csr_mret_d;
      csr_pc_q       <= csr_pc_d;
      out_valid_q    <= out_valid_d;
      out_rdata_q    <= out_rdata_d;
      out_redirect_q <= out_redirect_d;
      out_npc_q      <= out_npc_d;
      out_illegal_q  <= out_illegal_d;
      if (accept) begin
        f3_q    <= bus.in_funct3;
        ecall_q <= bus.in_is_ecall;
        mret_q  <= bus.in_is_mret && !bus.in_is_ecall;
        addr_q  <= bus.in_addr;
        rs1_q   <= bus.in_rs1;
        idx_q   <= bus.in_rs1_idx;
      end
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.csr_addr     = csr_addr_q;
  assign bus.csr_wdata    = csr_wdata_q;
  assign bus.csr_wen      = csr_wen_q;
  assign bus.csr_is_ecall = csr_ecall_q;
  assign bus.csr_is_mret  = csr_mret_q;
  assign bus.csr_pc       = csr_pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rdata    = out_rdata_q;
  assign bus.out_redirect = out_redirect_q;
  assign bus.out_npc      = out_npc_q;
  assign bus.out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl with a small behavioural CSR file on the access port.
// Expected responses and writes are queued at issue and popped as the DUT produces them.
module tb_csr_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;

`ifdef CSR_CTRL_ZICSR_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  csr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] rdata;
    logic          redirect;
    logic [DW-1:0] npc;
    logic          illegal;
    int            lat;
    int            acc;
    logic [DW-1:0] pc;
    int            n_ecall;
    int            n_mret;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t me;
  wr_t   mw;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_left = 0;
  int n_ecall = 0;
  int n_mret = 0;
  bit resp_active = 1'b0;

  // Behavioural CSR file; shadow is the bench's own expectation of its contents.
  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!rst) begin
      if (bus.csr_wen)      mem[bus.csr_addr] <= bus.csr_wdata;
      if (bus.csr_is_ecall) mem[12'h341]      <= bus.csr_pc;
    end
  end

  assign bus.csr_rdata = bus.csr_is_ecall ? mem[12'h305] :
                         bus.csr_is_mret  ? mem[12'h341] : mem[bus.csr_addr];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    shadow[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic send(input logic [2:0] f3, input logic ec, input logic mr,
                      input logic [AW-1:0] a, input logic [DW-1:0] rs1,
                      input logic [4:0] idx, input logic [DW-1:0] pc);
    resp_t e;
    int n;
    logic [DW-1:0] src, old, nv;
    logic legal;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_funct3 = f3; bus.in_is_ecall = ec; bus.in_is_mret = mr;
    bus.in_addr = a; bus.in_rs1 = rs1; bus.in_rs1_idx = idx; bus.in_pc = pc;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = '{rdata: '0, redirect: 1'b0, npc: '0, illegal: 1'b0, lat: 0, acc: cyc,
          pc: '0, n_ecall: 0, n_mret: 0};
    legal = (f3[1:0] != 2'b00) && (!f3[2] || IMM_EN);
    if (ec) begin
      e.redirect = 1'b1; e.npc = shadow[12'h305]; e.pc = pc; e.lat = 2; e.n_ecall = 1;
      shadow[12'h341] = pc;
    end else if (mr) begin
      e.redirect = 1'b1; e.npc = shadow[12'h341]; e.lat = 2; e.n_mret = 1;
    end else if (!legal) begin
      e.illegal = 1'b1; e.lat = 1;
    end else begin
      old = shadow[a];
      src = f3[2] ? {27'b0, idx} : rs1;
      case (f3[1:0])
        2'b01:   nv = src;
        2'b10:   nv = old | src;
        default: nv = old & ~src;
      endcase
      e.rdata = old; e.lat = 3;
      if (!(f3[1] && idx == 5'd0)) begin
        wq.push_back('{addr: a, data: nv});
        shadow[a] = nv;
      end
    end
    rq.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || resp_active) && n < 200) begin @(negedge clk); n++; end
    if (rq.size() != 0) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Response backpressure: out_ready changes just after the rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else bus.out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.csr_wen) begin
        if (wq.size() == 0) check("unexpected_wen", 1, 0);
        else begin
          mw = wq.pop_front();
          check("wen_addr", 64'(bus.csr_addr), 64'(mw.addr));
          check("wen_data", 64'(bus.csr_wdata), 64'(mw.data));
          if (rq.size() != 0) check("wen_cycle", 64'(cyc - rq[0].acc), 64'd2);
        end
      end
      if (bus.csr_is_ecall) begin
        n_ecall++;
        if (rq.size() != 0) begin
          check("ecall_pc", 64'(bus.csr_pc), 64'(rq[0].pc));
          check("ecall_cycle", 64'(cyc - rq[0].acc), 64'd1);
        end
      end
      if (bus.csr_is_mret) n_mret++;
      if (bus.out_valid) begin
        if (rq.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          me = rq[0];
          if (!resp_active) begin
            resp_active = 1'b1;
            check("latency", 64'(cyc - me.acc), 64'(me.lat));
          end
          check("in_ready_resp", 64'(bus.in_ready), 64'd0);
          check("out_rdata", 64'(bus.out_rdata), 64'(me.rdata));
          check("out_redirect", 64'(bus.out_redirect), 64'(me.redirect));
          check("out_npc", 64'(bus.out_npc), 64'(me.npc));
          check("out_illegal", 64'(bus.out_illegal), 64'(me.illegal));
          if (bus.out_ready) begin
            check("ecall_pulses", 64'(n_ecall), 64'(me.n_ecall));
            check("mret_pulses", 64'(n_mret), 64'(me.n_mret));
            check("pending_writes", 64'(wq.size()), 64'd0);
            void'(rq.pop_front());
            resp_active = 1'b0;
            n_ecall = 0;
            n_mret = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    int n;
    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_is_ecall = 1'b0; bus.in_is_mret = 1'b0;
    bus.in_addr = '0; bus.in_rs1 = '0; bus.in_rs1_idx = '0; bus.in_pc = '0;
    preload(12'h000, 32'h0);
    preload(12'h305, 32'h0);
    preload(12'h300, 32'h0000_1800);
    preload(12'h340, 32'h1234_5678);
    preload(12'h341, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_csr_wen", 64'(bus.csr_wen), 64'd0);
    check("rst_is_ecall", 64'(bus.csr_is_ecall), 64'd0);
    check("rst_is_mret", 64'(bus.csr_is_mret), 64'd0);

    send(3'b001, 1'b0, 1'b0, 12'h305, 32'h8000_0100, 5'd1, 32'h0);  // CSRRW
    send(3'b010, 1'b0, 1'b0, 12'h300, 32'h0000_0008, 5'd5, 32'h0);  // CSRRS
    send(3'b010, 1'b0, 1'b0, 12'h300, 32'h0000_0004, 5'd0, 32'h0);  // CSRRS x0: no write
    send(3'b011, 1'b0, 1'b0, 12'h300, 32'h0000_0008, 5'd3, 32'h0);  // CSRRC
    send(3'b011, 1'b0, 1'b0, 12'h300, 32'hFFFF_FFFF, 5'd0, 32'h0);  // CSRRC x0: no write
    wait_idle();

    preload(12'h305, 32'h8000_1000);
    send(3'b001, 1'b1, 1'b1, 12'h305, 32'h5, 5'd2, 32'h8000_0040);  // ecall wins
    send(3'b010, 1'b0, 1'b1, 12'h341, 32'h5, 5'd2, 32'h0);          // mret wins
    send(3'b000, 1'b0, 1'b0, 12'h300, 32'h1, 5'd1, 32'h0);
    send(3'b100, 1'b0, 1'b0, 12'h300, 32'h1, 5'd1, 32'h0);
    send(3'b110, 1'b0, 1'b0, 12'h300, 32'h0, 5'd5, 32'h0);          // CSRRSI
    send(3'b101, 1'b0, 1'b0, 12'h340, 32'h0, 5'd9, 32'h0);          // CSRRWI
    send(3'b111, 1'b0, 1'b0, 12'h340, 32'h0, 5'd0, 32'h0);          // CSRRCI x0
    wait_idle();

    stall_left = 5;
    send(3'b001, 1'b0, 1'b0, 12'h340, 32'hA5A5_0000, 5'd7, 32'h0);
    send(3'b010, 1'b0, 1'b0, 12'h340, 32'h0000_00F0, 5'd7, 32'h0);
    wait_idle();

    // Abort a write: reset lands during the WRITE cycle.
    send(3'b001, 1'b0, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd1, 32'h0);
    n = 0;
    while (!bus.csr_wen && n < 10) begin @(negedge clk); n++; end
    check("wen_seen_before_rst", 64'(bus.csr_wen), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wen", 64'(bus.csr_wen), 64'd0);
    check("rst_async_idle", 64'(bus.in_ready), 64'd1);
    check("rst_async_valid", 64'(bus.out_valid), 64'd0);
    rq.delete(); wq.delete();
    resp_active = 1'b0; n_ecall = 0; n_mret = 0;
    preload(12'h340, 32'h0F0F_0F0F);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    send(3'b110, 1'b0, 1'b0, 12'h340, 32'h0, 5'd5, 32'h0);
    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) f[2] = 1'b1;
      send(f, 1'b0, 1'b0, 12'h340, $urandom, 5'($urandom_range(0, 3)), 32'h0);
    end
    wait_idle();
    check("final_pending_writes", 64'(wq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
